// File: rtl/rgb_led_pattern_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_pattern_engine_if
// Brief    : Board-side signal bundle for the RGB LED pattern engine
//            (button in, per-LED R/G/B enables and current mode out).
// Revision : 1.0 - initial release
// ============================================================================
interface rgb_led_pattern_engine_if #(
    parameter int NUM_LEDS = 25
);
    logic                button;
    logic [NUM_LEDS-1:0] R;
    logic [NUM_LEDS-1:0] G;
    logic [NUM_LEDS-1:0] B;
    logic [1:0]          mode;

    modport master (output button, input R, G, B, mode);
    modport slave  (input button, output R, G, B, mode);
endinterface
`default_nettype wire

// File: rtl/rgb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_pattern_engine
// Brief    : Debounced button cycles OFF / colour cycle / breathe / rainbow;
//            per-LED, per-channel PWM drives the R/G/B enables.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_pattern_engine #(
    parameter int NUM_LEDS        = 25,
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_CYCLES     = 20000,
    parameter int COLOR_HOLD      = 100,
    parameter int LED_HUE_OFFSET  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    rgb_led_pattern_engine_if.slave      bus
);

    localparam int C_M       = 1 << PWM_BITS;
    localparam int C_HUE_MOD = 3 * C_M;
    localparam int C_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int C_TK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int C_HOLD_W  = (COLOR_HOLD > 1) ? $clog2(COLOR_HOLD) : 1;
    localparam int C_HUE_W   = PWM_BITS + 2;
    localparam int C_SUM_W   = PWM_BITS + 3;

    localparam logic [C_DB_W-1:0]   C_DB_LAST   = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_TK_W-1:0]   C_TK_LAST   = C_TK_W'(TICK_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(COLOR_HOLD - 1);
    localparam logic [C_HUE_W-1:0]  C_HUE_LAST  = C_HUE_W'(C_HUE_MOD - 1);
    localparam logic [PWM_BITS-1:0] C_DUTY_MAX  = PWM_BITS'(C_M - 1);
    localparam logic [PWM_BITS-1:0] C_P_LAST    = PWM_BITS'(C_M - 2);
    localparam logic [2:0]          C_IDX_LAST  = 3'd6;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_CYCLE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_RAINBOW = 2'd3
    } mode_e;

    // Colour table entry as {R,G,B} channel enables.
    function automatic logic [2:0] colour_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    colour_rgb = 3'b100;
            3'd1:    colour_rgb = 3'b010;
            3'd2:    colour_rgb = 3'b001;
            3'd3:    colour_rgb = 3'b110;
            3'd4:    colour_rgb = 3'b011;
            3'd5:    colour_rgb = 3'b101;
            default: colour_rgb = 3'b111;
        endcase
    endfunction

    logic                sync1_q, sync2_q;
    logic                db_q, db_d;
    logic [C_DB_W-1:0]   dcnt_q, dcnt_d;
    logic                w_press;
    mode_e               mode_q, mode_d;
    logic [C_TK_W-1:0]   presc_q, presc_d;
    logic                w_tick;
    logic [C_HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]          idx_q, idx_d, w_idx_next;
    logic [2:0]          w_mask;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                up_q, up_d;
    logic [C_HUE_W-1:0]  hue_q, hue_d;
    logic [PWM_BITS-1:0] p_q, p_d;
    logic [NUM_LEDS-1:0] red_q, grn_q, blu_q;
    logic [NUM_LEDS-1:0] w_red_on, w_grn_on, w_blu_on;

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d    = db_q;
        dcnt_d  = dcnt_q;
        w_press = 1'b0;
        if (sync2_q == db_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == C_DB_LAST) begin
            db_d    = sync2_q;
            dcnt_d  = '0;
            w_press = ~sync2_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (w_press) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
    end

    assign w_idx_next = (idx_q == C_IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    assign w_mask     = colour_rgb(idx_q);
    assign w_tick     = (presc_q == C_TK_LAST) && !w_press;
    assign p_d        = (p_q == C_P_LAST) ? '0 : p_q + 1'b1;

    // Pattern state; a press restarts the pattern and swallows a same-cycle tick.
    always_comb begin
        presc_d = presc_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        level_d = level_q;
        up_d    = up_q;
        hue_d   = hue_q;
        if (w_press) begin
            presc_d = '0;
            hold_d  = '0;
            idx_d   = '0;
            level_d = '0;
            up_d    = 1'b1;
            hue_d   = '0;
        end else begin
            presc_d = (presc_q == C_TK_LAST) ? '0 : presc_q + 1'b1;
            if (w_tick) begin
                case (mode_q)
                    MODE_CYCLE: begin
                        if (hold_q == C_HOLD_LAST) begin
                            hold_d = '0;
                            idx_d  = w_idx_next;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    MODE_BREATHE: begin
                        if (up_q) begin
                            if (level_q == C_DUTY_MAX) up_d = 1'b0;
                            else                       level_d = level_q + 1'b1;
                        end else begin
                            if (level_q == '0) begin
                                up_d  = 1'b1;
                                idx_d = w_idx_next;
                            end else begin
                                level_d = level_q - 1'b1;
                            end
                        end
                    end
                    MODE_RAINBOW: hue_d = (hue_q == C_HUE_LAST) ? '0 : hue_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        // Per-LED hue offset folded at elaboration so the runtime sum stays below 2*3M.
        localparam int C_OFF = (gi * LED_HUE_OFFSET) % C_HUE_MOD;

        logic [C_SUM_W-1:0]  w_hsum, w_hi;
        logic [PWM_BITS-1:0] w_x, w_xn;
        logic [PWM_BITS-1:0] w_duty_r, w_duty_g, w_duty_b;

        always_comb begin
            w_hsum   = C_SUM_W'(hue_q) + C_SUM_W'(C_OFF);
            w_hi     = (w_hsum >= C_SUM_W'(C_HUE_MOD)) ? w_hsum - C_SUM_W'(C_HUE_MOD) : w_hsum;
            w_x      = w_hi[PWM_BITS-1:0];
            w_xn     = C_DUTY_MAX - w_x;
            w_duty_r = '0;
            w_duty_g = '0;
            w_duty_b = '0;
            case (mode_q)
                MODE_CYCLE: begin
                    w_duty_r = w_mask[2] ? C_DUTY_MAX : '0;
                    w_duty_g = w_mask[1] ? C_DUTY_MAX : '0;
                    w_duty_b = w_mask[0] ? C_DUTY_MAX : '0;
                end
                MODE_BREATHE: begin
                    w_duty_r = w_mask[2] ? level_q : '0;
                    w_duty_g = w_mask[1] ? level_q : '0;
                    w_duty_b = w_mask[0] ? level_q : '0;
                end
                MODE_RAINBOW: begin
                    case (w_hi[C_SUM_W-1:PWM_BITS])
                        3'd0: begin
                            w_duty_r = w_xn;
                            w_duty_g = w_x;
                        end
                        3'd1: begin
                            w_duty_g = w_xn;
                            w_duty_b = w_x;
                        end
                        default: begin
                            w_duty_b = w_xn;
                            w_duty_r = w_x;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        assign w_red_on[gi] = (p_q < w_duty_r);
        assign w_grn_on[gi] = (p_q < w_duty_g);
        assign w_blu_on[gi] = (p_q < w_duty_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            dcnt_q  <= '0;
            mode_q  <= MODE_OFF;
            presc_q <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            level_q <= '0;
            up_q    <= 1'b1;
            hue_q   <= '0;
            p_q     <= '0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            up_q    <= up_d;
            hue_q   <= hue_d;
            p_q     <= p_d;
            red_q   <= w_red_on;
            grn_q   <= w_grn_on;
            blu_q   <= w_blu_on;
        end
    end

    assign bus.R    = red_q;
    assign bus.G    = grn_q;
    assign bus.B    = blu_q;
    assign bus.mode = mode_q;

endmodule
`default_nettype wire
